// File: rtl/lmul_operand_fifo_if.sv
// Operand-pair handshake bundle between the upstream producer,
// the operand FIFO and the BF16 multiplier.
interface lmul_operand_fifo_if #(
  parameter int W = 16
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_a;
  logic [W-1:0] s_b;
  logic         o_valid;
  logic         o_ready;
  logic [W-1:0] o_a;
  logic [W-1:0] o_b;

  modport master (
    output s_valid, s_a, s_b, o_ready,
    input  s_ready, o_valid, o_a, o_b
  );

  modport slave (
    input  s_valid, s_a, s_b, o_ready,
    output s_ready, o_valid, o_a, o_b
  );
endinterface

// File: rtl/lmul_operand_fifo.sv
// First-word-fall-through FIFO of BF16 operand pairs feeding
// the multiplier; tracks fill level and delivered-pair count.
module lmul_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  lmul_operand_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [15:0]              o_pairs
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [2*W-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [LW-1:0]  r_level;
  logic [15:0]    r_pairs;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic [2*W-1:0] w_head;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // rstn gates s_ready so it is low while reset is held.
  assign bus.s_ready = rstn & ~w_full;
  assign bus.o_valid = ~w_empty;

  assign w_push = bus.s_valid & bus.s_ready & ~flush;
  assign w_pop  = bus.o_valid & bus.o_ready & ~flush;

  assign w_head  = r_mem[r_rd];
  assign bus.o_a = bus.o_valid ? w_head[2*W-1:W] : '0;
  assign bus.o_b = bus.o_valid ? w_head[W-1:0]   : '0;

  assign o_level = r_level;
  assign o_pairs = r_pairs;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= {bus.s_a, bus.s_b};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_pairs <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd    <= r_rd + AW'(1);
        r_pairs <= r_pairs + 16'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: tb/tb_lmul_operand_fifo.sv
// Directed bench for lmul_operand_fifo (DEPTH=4, W=16):
// reset, fall-through, full/back-pressure, flush, ordering.
module tb_lmul_operand_fifo;
  logic        clk;
  logic        rstn;
  logic        flush;
  logic [2:0]  level;
  logic [15:0] pairs;

  int checks   = 0;
  int failures = 0;

  lmul_operand_fifo_if #(.W(16)) bus ();

  lmul_operand_fifo #(
    .DEPTH(4),
    .W(16)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .bus     (bus),
    .o_level (level),
    .o_pairs (pairs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    int         pushed;
    int         popped;
    logic       fp;
    logic       fq;

    rstn        = 1'b0;
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.o_ready = 1'b0;
    step();
    step();
    chk("rst_o_valid", 32'(bus.o_valid), 0);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_level",   32'(level), 0);
    chk("rst_pairs",   32'(pairs), 0);
    chk("rst_o_a",     32'(bus.o_a), 0);

    rstn = 1'b1;
    #1;
    chk("rel_s_ready", 32'(bus.s_ready), 1);
    chk("rel_o_valid", 32'(bus.o_valid), 0);

    // single push, stalled consumer
    bus.s_valid = 1'b1;
    bus.s_a     = 16'h3F80;
    bus.s_b     = 16'h4000;
    step();
    bus.s_valid = 1'b0;
    chk("p1_o_valid", 32'(bus.o_valid), 1);
    chk("p1_o_a",     32'(bus.o_a), 32'h3F80);
    chk("p1_o_b",     32'(bus.o_b), 32'h4000);
    chk("p1_level",   32'(level), 1);

    // fill to DEPTH
    for (int k = 1; k <= 3; k++) begin
      bus.s_valid = 1'b1;
      bus.s_a     = 16'(16'h1000 + k);
      bus.s_b     = 16'(16'h2000 + k);
      step();
    end
    chk("full_s_ready", 32'(bus.s_ready), 0);
    chk("full_level",   32'(level), 4);

    // 5th pair held upstream
    bus.s_a = 16'h1004;
    bus.s_b = 16'h2004;
    step();
    chk("held_level", 32'(level), 4);
    chk("held_o_a",   32'(bus.o_a), 32'h3F80);
    chk("held_o_b",   32'(bus.o_b), 32'h4000);
    chk("held_o_vld", 32'(bus.o_valid), 1);

    // full with pop: first cycle pops only
    bus.o_ready = 1'b1;
    step();
    chk("fp_level",   32'(level), 3);
    chk("fp_o_a",     32'(bus.o_a), 32'h1001);
    chk("fp_s_ready", 32'(bus.s_ready), 1);
    step();
    chk("cc1_level", 32'(level), 3);
    chk("cc1_o_a",   32'(bus.o_a), 32'h1002);
    bus.s_a = 16'h1005;
    bus.s_b = 16'h2005;
    step();
    chk("cc2_level", 32'(level), 3);
    chk("cc2_o_a",   32'(bus.o_a), 32'h1003);
    chk("cc2_o_b",   32'(bus.o_b), 32'h2003);
    chk("cc2_pairs", 32'(pairs), 3);

    // flush with 3 entries and a concurrent offer
    flush       = 1'b1;
    bus.s_a     = 16'hBEEF;
    bus.s_b     = 16'hCAFE;
    step();
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    bus.o_ready = 1'b0;
    chk("fl_level",   32'(level), 0);
    chk("fl_o_valid", 32'(bus.o_valid), 0);
    chk("fl_o_a",     32'(bus.o_a), 0);
    chk("fl_pairs",   32'(pairs), 3);

    // 10 pairs through with consumer stalls
    pat    = 8'b1011_0010;
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 80 && popped < 10; c++) begin
      bus.s_valid = (pushed < 10);
      bus.s_a     = 16'(16'h5000 + pushed);
      bus.s_b     = 16'(16'h6000 + pushed);
      bus.o_ready = pat[c % 8];
      #1;
      fp = bus.s_valid & bus.s_ready;
      fq = bus.o_valid & bus.o_ready;
      if (fq) begin
        chk("ord_o_a", 32'(bus.o_a), 32'h5000 + 32'(popped));
        chk("ord_o_b", 32'(bus.o_b), 32'h6000 + 32'(popped));
      end
      step();
      if (fp) pushed++;
      if (fq) popped++;
    end
    bus.s_valid = 1'b0;
    bus.o_ready = 1'b0;
    chk("ord_popped", 32'(popped), 10);
    chk("ord_pairs",  32'(pairs), 13);
    chk("ord_level",  32'(level), 0);

    // async reset mid-cycle
    bus.s_valid = 1'b1;
    bus.s_a     = 16'h7777;
    bus.s_b     = 16'h8888;
    step();
    bus.s_valid = 1'b0;
    chk("ar_pre_level", 32'(level), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_o_valid", 32'(bus.o_valid), 0);
    chk("ar_level",   32'(level), 0);
    chk("ar_pairs",   32'(pairs), 0);
    chk("ar_s_ready", 32'(bus.s_ready), 0);
    step();
    rstn        = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_a     = 16'h1234;
    bus.s_b     = 16'h5678;
    step();
    bus.s_valid = 1'b0;
    chk("ar_post_vld",   32'(bus.o_valid), 1);
    chk("ar_post_o_a",   32'(bus.o_a), 32'h1234);
    chk("ar_post_o_b",   32'(bus.o_b), 32'h5678);
    chk("ar_post_level", 32'(level), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
